collision_manager: RTL
======================

COLLISION_MANAGER -- requirements
Module: collision_manager

Interface
REQ-001 Parameter NUM_SHOTS, default 3: number of independent shot drawing channels, legal range 1..8.
REQ-002 Parameter NUM_ENEMIES, default 4: number of independent enemy drawing channels, legal range 1..16.
REQ-003 Parameter SCORE_W, default 8: width of the score accumulator.
REQ-004 clk  input  1: system clock. One clock only.
REQ-005 resetN  input  1: reset, asynchronous, active-low.
REQ-006 startOfFrame  input  1: one-cycle pulse at the start of each frame.
REQ-007 clearScore  input  1: synchronous score clear, level-sampled each cycle.
REQ-008 drawing_request_player  input  1: player pixel active.
REQ-009 drawing_request_tower  input  1: tower pixel active.
REQ-010 drawing_request_shot  input  NUM_SHOTS: per-shot pixel active.
REQ-011 drawing_request_enemy  input  NUM_ENEMIES: per-enemy pixel active.
REQ-012 shotEnemyHit  output  NUM_SHOTS: per shot, hit any enemy last frame; one-cycle pulse.
REQ-013 enemyHit  output  NUM_ENEMIES: per enemy, hit by any shot last frame; one-cycle pulse.
REQ-014 shotTowerHit  output  NUM_SHOTS: per shot, overlapped tower last frame; one-cycle pulse.
REQ-015 playerTowerHit  output  1: player overlapped tower last frame; one-cycle pulse.
REQ-016 singleHitPulse  output  1: first collision of any kind in the current frame; one-cycle pulse.
REQ-017 score  output  SCORE_W: saturating count of enemies hit, accumulated across frames.

Function
REQ-018 Pixel collisions are combinational per cycle: shot s/enemy e when both requests are high; shot s/tower when shot s and tower are high; player/tower when both are high.
REQ-019 Sticky accumulators: shot-enemy (NUM_SHOTS bits), enemy (NUM_ENEMIES bits), shot-tower (NUM_SHOTS bits), player-tower (1 bit). Each accumulator bit ORs in its pixel collision every cycle.
REQ-020 On a startOfFrame cycle, all accumulators are copied to the output registers. Outputs are high for exactly the next cycle only and are 0 in every other cycle.
REQ-021 On a startOfFrame cycle, each accumulator is loaded with that cycle's pixel collision, not cleared to 0. That pixel belongs to the new frame.
REQ-022 A frame with no collisions produces all-zero outputs after startOfFrame.
REQ-023 Flag bit hitFlag clears on startOfFrame.
REQ-024 The first cycle with any pixel collision while hitFlag=0 sets hitFlag and drives singleHitPulse high in the following cycle. At most one singleHitPulse per frame.
REQ-025 If the collision occurs on the startOfFrame cycle itself, singleHitPulse still fires for the new frame.
REQ-026 In the cycle after startOfFrame, score increases by popcount(enemy accumulator), saturating at 2^SCORE_W-1 with no wrap.
REQ-027 clearScore high sets score to 0 next cycle. It takes priority over a simultaneous increment.
REQ-028 Latency: frame result outputs and score update appear 1 cycle after startOfFrame; singleHitPulse appears 1 cycle after the triggering pixel.
REQ-029 Every accumulator bit is independent. Multiple simultaneous collisions in one cycle set every matching bit.

Reset
REQ-030 resetN low asynchronously clears all accumulators, all output registers, hitFlag and score to 0.
REQ-031 Reset mid-frame discards partial-frame results. The first startOfFrame after release reports only collisions seen since release.
REQ-032 While resetN is low, all outputs are 0 regardless of inputs.

Verification
REQ-033 shot[1] and enemy[2] overlap for 5 cycles mid-frame, then startOfFrame -> shotEnemyHit=3'b010 and enemyHit=4'b0100 for 1 cycle; score 0->1; singleHitPulse once, 1 cycle after first overlap.
REQ-034 shot[0] hits enemy[0] and shot[2] hits enemy[3] in the same frame -> enemyHit=4'b1001; score increases by 2; singleHitPulse only once.
REQ-035 Collision pixel coincident with startOfFrame -> it is absent from the pulse for the closing frame and present at the next startOfFrame; singleHitPulse fires in the cycle after.
REQ-036 SCORE_W=2 with 5 enemy-hit frames -> score reaches 3 and stays 3. clearScore asserted together with an increment cycle -> score=0.
REQ-037 Player/tower overlap, then resetN pulsed low mid-frame, then startOfFrame -> playerTowerHit stays 0; all outputs are 0 during reset.
REQ-038 NUM_SHOTS=1, NUM_ENEMIES=1 build; shot overlaps tower only -> shotTowerHit=1 and enemyHit=0 after startOfFrame.

Source files
------------

// File: rtl/collision_manager.sv
// Per-frame collision detector: accumulates pixel overlaps, reports them as one-cycle pulses after startOfFrame, keeps a saturating score.
// Frame results and score appear 1 cycle after startOfFrame; singleHitPulse 1 cycle after the first colliding pixel of a frame.
module collision_manager #(
  parameter int NUM_SHOTS   = 3,
  parameter int NUM_ENEMIES = 4,
  parameter int SCORE_W     = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   clearScore,
  input  logic                   drawing_request_player,
  input  logic                   drawing_request_tower,
  input  logic [NUM_SHOTS-1:0]   drawing_request_shot,
  input  logic [NUM_ENEMIES-1:0] drawing_request_enemy,
  output logic [NUM_SHOTS-1:0]   shotEnemyHit,
  output logic [NUM_ENEMIES-1:0] enemyHit,
  output logic [NUM_SHOTS-1:0]   shotTowerHit,
  output logic                   playerTowerHit,
  output logic                   singleHitPulse,
  output logic [SCORE_W-1:0]     score
);

  localparam int CNT_W = $clog2(NUM_ENEMIES + 1);
  localparam int SUM_W = SCORE_W + CNT_W;

  logic [NUM_SHOTS-1:0]   pix_shot_enemy, pix_shot_tower;
  logic [NUM_ENEMIES-1:0] pix_enemy;
  logic                   pix_player_tower, any_pix;

  logic [NUM_SHOTS-1:0]   acc_shot_enemy, acc_shot_tower;
  logic [NUM_ENEMIES-1:0] acc_enemy;
  logic                   acc_player_tower, hit_flag;

  logic [CNT_W-1:0]   hit_cnt;
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;

  assign pix_shot_enemy   = drawing_request_shot & {NUM_SHOTS{|drawing_request_enemy}};
  assign pix_enemy        = drawing_request_enemy & {NUM_ENEMIES{|drawing_request_shot}};
  assign pix_shot_tower   = drawing_request_shot & {NUM_SHOTS{drawing_request_tower}};
  assign pix_player_tower = drawing_request_player & drawing_request_tower;
  assign any_pix          = (|pix_shot_enemy) | (|pix_shot_tower) | pix_player_tower;

  always_comb begin
    hit_cnt = '0;
    for (int e = 0; e < NUM_ENEMIES; e++) begin
      hit_cnt = hit_cnt + CNT_W'(acc_enemy[e]);
    end
  end

  // Any carry past SCORE_W bits means the score is pinned at all-ones.
  assign score_sum = SUM_W'(score) + SUM_W'(hit_cnt);
  assign score_sat = (|score_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_shot_enemy   <= '0;
      acc_enemy        <= '0;
      acc_shot_tower   <= '0;
      acc_player_tower <= 1'b0;
      shotEnemyHit     <= '0;
      enemyHit         <= '0;
      shotTowerHit     <= '0;
      playerTowerHit   <= 1'b0;
      hit_flag         <= 1'b0;
      singleHitPulse   <= 1'b0;
      score            <= '0;
    end else begin
      if (startOfFrame) begin
        // The boundary pixel already belongs to the new frame.
        shotEnemyHit     <= acc_shot_enemy;
        enemyHit         <= acc_enemy;
        shotTowerHit     <= acc_shot_tower;
        playerTowerHit   <= acc_player_tower;
        acc_shot_enemy   <= pix_shot_enemy;
        acc_enemy        <= pix_enemy;
        acc_shot_tower   <= pix_shot_tower;
        acc_player_tower <= pix_player_tower;
      end else begin
        shotEnemyHit     <= '0;
        enemyHit         <= '0;
        shotTowerHit     <= '0;
        playerTowerHit   <= 1'b0;
        acc_shot_enemy   <= acc_shot_enemy | pix_shot_enemy;
        acc_enemy        <= acc_enemy | pix_enemy;
        acc_shot_tower   <= acc_shot_tower | pix_shot_tower;
        acc_player_tower <= acc_player_tower | pix_player_tower;
      end

      hit_flag       <= startOfFrame ? any_pix : (hit_flag | any_pix);
      singleHitPulse <= any_pix & (startOfFrame | ~hit_flag);

      if (clearScore) begin
        score <= '0;
      end else if (startOfFrame) begin
        score <= score_sat;
      end
    end
  end

endmodule
